// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU between the integer execute
// stage (port 0) and the FP/multiply issue path (port 1), holding each response until it is consumed.
module alu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8,
  parameter int FP_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_result_hi,
  output logic [3:0]  rsp_flags,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctl,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result_hi,
  input  logic [3:0]  alu_flags,

  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_UMUL  = 4'b0101;
  localparam logic [3:0] OP_SMUL  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b0111;
  localparam logic [3:0] OP_FADDS = 4'b1000;
  localparam logic [3:0] OP_FMULS = 4'b1001;

  // Counter preload values are latency minus one: cnt==0 marks the final EXEC cycle.
  localparam logic [3:0] MUL_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_CYCLES - 1);
  localparam logic [3:0] FP_M1  = 4'(FP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [3:0]  flags_q, flags_d;

  logic        any_valid;
  logic        grant;
  logic        accept;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;
  logic        div_zero;
  logic        owner_rsp_ready;

  function automatic logic [3:0] lat_m1(input logic [3:0] op, input logic [31:0] b);
    case (op)
      OP_DIV:                   return (b == 32'd0) ? 4'd0 : DIV_M1;
      OP_UMUL, OP_SMUL, OP_MUL: return MUL_M1;
      OP_FADDS, OP_FMULS:       return FP_M1;
      default:                  return 4'd0;
    endcase
  endfunction

  // On a tie the port that did not win last time is served.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign accept    = (state_q == S_IDLE) & any_valid;

  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;
  assign sel_op = grant ? req1_op : req0_op;

  assign div_zero        = (op_q == OP_DIV) && (b_q == 32'd0);
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // NOTE: every variable gets a default at the top of the block so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    res_hi_d     = res_hi_q;
    flags_d      = flags_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = sel_a;
          b_d          = sel_b;
          op_d         = sel_op;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = lat_m1(sel_op, sel_b);
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d    = div_zero ? 32'hFFFF_FFFF : alu_result;
          res_hi_d = div_zero ? 32'd0         : alu_result_hi;
          flags_d  = div_zero ? 4'b1000       : alu_flags;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: operand and response registers are reset too, because they drive the
  // alu_* and rsp_* outputs directly and must read 0 while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 4'd0;
      res_q        <= 32'd0;
      res_hi_q     <= 32'd0;
      flags_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      res_hi_q     <= res_hi_d;
      flags_q      <= flags_d;
    end
  end

  // Readies are gated by reset because the reset state itself is IDLE.
  assign req0_ready = reset & accept & ~grant;
  assign req1_ready = reset & accept &  grant;

  assign rsp0_valid    = (state_q == S_RESP) & ~owner_q;
  assign rsp1_valid    = (state_q == S_RESP) &  owner_q;
  assign rsp_result    = res_q;
  assign rsp_result_hi = res_hi_q;
  assign rsp_flags     = flags_q;

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_ctl = op_q;

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, randomized ops against a
// latency/result reference model, and hand-written contention/backpressure/reset sequences.
module tb_alu_arbiter;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 8;
  localparam int FP_CYCLES  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result, rsp_result_hi;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_a, alu_b, alu_result, alu_result_hi;
  logic [3:0]  alu_ctl, alu_flags;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .FP_CYCLES (FP_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp_result   (rsp_result),
    .rsp_result_hi(rsp_result_hi),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctl      (alu_ctl),
    .alu_result   (alu_result),
    .alu_result_hi(alu_result_hi),
    .alu_flags    (alu_flags),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags, hi, lo}; FP codes use integer stand-ins.
  function automatic logic [67:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctl);
    logic [31:0] lo, hi;
    logic [63:0] p;
    lo = 32'd0;
    hi = 32'd0;
    case (ctl)
      4'b0000: lo = a + b;
      4'b0001: lo = a - b;
      4'b0010: lo = a & b;
      4'b0011: lo = a | b;
      4'b0100: lo = (b == 32'd0) ? 32'h1234_5678 : a / b;
      4'b0101: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
      4'b0110: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); {hi, lo} = p; end
      4'b0111: lo = a * b;
      4'b1000: lo = a + b;
      4'b1001: lo = a * b;
      default: lo = a ^ b;
    endcase
    return {lo[31], (lo == 32'd0), 2'b00, hi, lo};
  endfunction

  assign {alu_flags, alu_result_hi, alu_result} = alu_fn(alu_a, alu_b, alu_ctl);

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0100) return (b == 32'd0) ? 1 : DIV_CYCLES;
    if (op inside {4'b0101, 4'b0110, 4'b0111}) return MUL_CYCLES;
    if (op inside {4'b1000, 4'b1001}) return FP_CYCLES;
    return 1;
  endfunction

  function automatic logic [67:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    if (op == 4'b0100 && b == 32'd0) return {4'b1000, 32'd0, 32'hFFFF_FFFF};
    return alu_fn(a, b, op);
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
    if (port == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic drive_rsp_ready(input int port, input logic v);
    if (port == 0) rsp0_ready = v;
    else rsp1_ready = v;
  endtask

  function automatic logic get_ready(input int port);
    return (port == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic get_rsp_valid(input int port);
    return (port == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one op, measure EXEC length, check the response, optionally backpressure it.
  task automatic run_op(input string name, input int port, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op, input logic [67:0] exp,
                        input int exp_lat, input int hold);
    int waited, lat;
    logic held, stable;
    logic [67:0] snap;
    @(negedge clk);
    drive_req(port, 1'b1, a, b, op);
    #1;
    waited = 0;
    while (!get_ready(port) && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check({name, " ready"}, get_ready(port), 1'b1);
    @(negedge clk);
    drive_req(port, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 0;
    held = 1'b1;
    while (!get_rsp_valid(port) && lat < 40) begin
      if (alu_a !== a || alu_b !== b || alu_ctl !== op || busy !== 1'b1) held = 1'b0;
      lat++;
      @(negedge clk);
    end
    check({name, " exec cycles"}, lat, exp_lat);
    check({name, " alu held"}, held, 1'b1);
    check({name, " other rsp valid"}, get_rsp_valid(1 - port), 1'b0);
    check({name, " rsp"}, {rsp_flags, rsp_result_hi, rsp_result}, exp);
    if (hold > 0) begin
      snap = {rsp_flags, rsp_result_hi, rsp_result};
      stable = 1'b1;
      drive_rsp_ready(1 - port, 1'b1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!get_rsp_valid(port) || {rsp_flags, rsp_result_hi, rsp_result} !== snap) stable = 1'b0;
      end
      drive_rsp_ready(1 - port, 1'b0);
      check({name, " rsp held"}, stable, 1'b1);
    end
    drive_rsp_ready(port, 1'b1);
    @(negedge clk);
    drive_rsp_ready(port, 1'b0);
    check({name, " back to idle"}, busy, 1'b0);
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  flags;
    int          lat;
    int          hold;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    logic [3:0] ops[12];
    int gp[$];
    int gc[$];
    int cyc;
    logic ok;

    vecs[0] = '{0, 32'd5,          32'd7,       4'b0000, 32'd12,         32'd0,          4'b0000, 1, 0};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'd2,       4'b0101, 32'hFFFF_FFFE,  32'd1,          4'b1000, 2, 0};
    vecs[2] = '{0, 32'd10,         32'd0,       4'b0100, 32'hFFFF_FFFF,  32'd0,          4'b1000, 1, 0};
    vecs[3] = '{0, 32'd100,        32'd7,       4'b0100, 32'd14,         32'd0,          4'b0000, 8, 0};
    vecs[4] = '{1, 32'd3,          32'd4,       4'b1000, 32'd7,          32'd0,          4'b0000, 3, 2};
    vecs[5] = '{0, 32'd5,          32'd5,       4'b0001, 32'd0,          32'd0,          4'b0100, 1, 0};
    vecs[6] = '{1, 32'hFFFF_FFFF,  32'd3,       4'b0110, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000, 2, 1};
    vecs[7] = '{0, 32'h0000_00F0,  32'h0000_000F, 4'b1111, 32'h0000_00FF, 32'd0,        4'b0000, 1, 0};
    vecs[8] = '{1, 32'd6,          32'd7,       4'b1001, 32'd42,         32'd0,          4'b0000, 3, 0};
    vecs[9] = '{0, 32'h0001_0000,  32'h0001_0000, 4'b0111, 32'd0,        32'd0,          4'b0100, 2, 0};

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    // Reset state, with both requests already valid.
    rst_n = 1'b0;
    drive_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
    drive_req(1, 1'b1, 32'd2, 32'd2, 4'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset handshakes", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 5'b0);
    check("reset alu outputs", {alu_a, alu_b, alu_ctl}, 68'd0);
    check("reset rsp outputs", {rsp_flags, rsp_result_hi, rsp_result}, 68'd0);
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op,
             {vecs[i].flags, vecs[i].hi, vecs[i].res}, vecs[i].lat, vecs[i].hold);
    end

    for (int i = 0; i < 30; i++) begin
      int          port, hold;
      logic [3:0]  op;
      logic [31:0] a, b;
      port = int'($urandom_range(0, 1));
      op   = ops[$urandom_range(0, 11)];
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      hold = int'($urandom_range(0, 2));
      run_op($sformatf("rand%0d", i), port, a, b, op, ref_rsp(a, b, op), ref_lat(op, b), hold);
    end

    // Contention: both ports valid from reset, responses consumed immediately.
    do_reset();
    @(negedge clk);
    drive_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
    drive_req(1, 1'b1, 32'd3, 32'd4, 4'b0000);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    cyc = 0;
    while (gp.size() < 4 && cyc < 40) begin
      #1;
      if (req0_ready) begin gp.push_back(0); gc.push_back(cyc); end
      if (req1_ready) begin gp.push_back(1); gc.push_back(cyc); end
      if (rsp0_valid) check("contention rsp0 result", rsp_result, 32'd3);
      if (rsp1_valid) check("contention rsp1 result", rsp_result, 32'd7);
      @(negedge clk);
      cyc++;
    end
    check("contention grant count", gp.size(), 4);
    for (int i = 0; i < gp.size(); i++) begin
      check($sformatf("contention grant%0d port", i), gp[i], i % 2);
      if (i > 0) check($sformatf("contention grant%0d spacing", i), gc[i] - gc[i-1], 3);
    end
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("contention drained", busy, 1'b0);

    // Backpressure on port 0 with port 1 pending.
    do_reset();
    @(negedge clk);
    drive_req(0, 1'b1, 32'd9, 32'd1, 4'b0000);
    drive_req(1, 1'b1, 32'd2, 32'd2, 4'b0000);
    #1;
    check("bp first grant", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    check("bp no grant while exec", req1_ready, 1'b0);
    @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!rsp0_valid || rsp1_valid || rsp_result !== 32'd10 || rsp_flags !== 4'b0000 ||
          req1_ready) ok = 1'b0;
      rsp1_ready = 1'b1;
      @(negedge clk);
    end
    check("bp rsp0 held 5 cycles", ok, 1'b1);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("bp bubble on consume", {rsp0_valid, req1_ready}, 2'b10);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp port1 granted next", req1_ready, 1'b1);
    @(negedge clk);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    check("bp port1 rsp", {rsp1_valid, rsp0_valid, rsp_result}, {2'b10, 32'd4});
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Reset during the 4th EXEC cycle of a DIV.
    do_reset();
    @(negedge clk);
    drive_req(0, 1'b1, 32'd100, 32'd7, 4'b0100);
    #1;
    check("rst div accepted", req0_ready, 1'b1);
    @(negedge clk);
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst mid exec busy", busy, 1'b1);
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("rst handshakes zero",
          {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 5'b0);
    check("rst alu zero", {alu_a, alu_b, alu_ctl}, 68'd0);
    check("rst rsp zero", {rsp_flags, rsp_result_hi, rsp_result}, 68'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) ok = 1'b0;
    end
    check("rst no late response", ok, 1'b1);
    drive_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    drive_req(1, 1'b1, 32'd1, 32'd1, 4'b0000);
    #1;
    check("rst tie goes to port0", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single multi-cycle ALU between two requesters: port 0 is the integer execute stage and port 1 is the FP/multiply issue path. The block arbitrates round-robin and latches the operands of the winning request. It drives them onto the ALU for an op-dependent number of cycles, then captures Result, ResultHi and ALUFlags into a response register. The response is held until the owning requester accepts it. The block sits between the control unit's issue logic and the ALU instance.

## Interface
Parameters:
- MUL_CYCLES, 2, ALU cycles for MUL (0111), SMUL (0110), UMUL (0101); legal range 1..15
- DIV_CYCLES, 8, ALU cycles for DIV (0100); legal range 1..15
- FP_CYCLES, 3, ALU cycles for FADDS (1000), FMULS (1001); legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  4  ALUControl code
- rsp0_valid / rsp1_valid  out  1  response for port 0 / 1 is held on rsp_*
- rsp0_ready / rsp1_ready  in  1  owner consumes the response
- rsp_result  out  32  captured ALU Result
- rsp_result_hi  out  32  captured ALU ResultHi
- rsp_flags  out  4  captured ALUFlags {N,Z,C,V}
- alu_a, alu_b  out  32  operands to the ALU
- alu_ctl  out  4  ALUControl to the ALU
- alu_result, alu_result_hi  in  32  ALU outputs
- alu_flags  in  4  ALU flags
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Op latency L:
  - DIV: L = DIV_CYCLES.
  - MUL/SMUL/UMUL: L = MUL_CYCLES.
  - FADDS/FMULS: L = FP_CYCLES.
  - All other codes: L = 1.
- Arbitration in IDLE, combinational grant:
  - Exactly one valid: that port is granted.
  - Both valid: the port other than last_grant is granted.
- Ready signals:
  - reqN_ready = (state==IDLE) && grant==N.
  - The non-granted port's ready is 0.
- Accept (IDLE, valid&ready):
  - Latch a, b and op into operand registers.
  - Set owner = grant and last_grant = grant.
  - Load cnt = L-1.
  - Go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_ctl are driven from the operand registers and stay constant for all L cycles.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture alu_result, alu_result_hi and alu_flags into the rsp registers, then go to RESP.
- DIV by zero (op 0100, b==0):
  - Accepted normally, but L is forced to 1.
  - Captured values are overridden: rsp_result=32'hFFFF_FFFF, rsp_result_hi=0, rsp_flags=4'b1000.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid is 0.
  - rsp_* outputs are stable while valid.
  - On rsp<owner>_ready=1, go to IDLE.
  - rsp ready on the non-owner port is ignored.
- IDLE/RESP: alu_a, alu_b, alu_ctl keep their last registered values. Only EXEC-cycle ALU output is meaningful.
- Unsupported ALUControl codes are passed through with L=1. The result is whatever the ALU returns.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State=IDLE, last_grant=1 (so port 0 wins the first tie), cnt=0, owner=0.
  - All operand and rsp registers 0; alu_* = 0.
  - All ready/valid outputs and busy = 0 while reset=0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is discarded and no response is ever issued.
- Request/response cycles:
  - Accept edge at end of cycle T.
  - EXEC occupies cycles T+1..T+L; capture occurs on the edge ending T+L.
  - rsp valid is asserted from cycle T+L+1.
  - If rsp ready is high in T+L+1, the block is back in IDLE in T+L+2 and can accept again in that cycle.
  - Minimum request-to-request spacing: L+2 cycles.
- No request is accepted in the same cycle a response is consumed (one-cycle bubble).
- Requests arriving while busy wait with valid held; requesters must hold a/b/op stable until ready.
- Simultaneous valid with alternating service: with both ports continuously valid, grants strictly alternate 0,1,0,1…

## Test plan
- Single ADD on port 0: a=5, b=7, op=0000 -> ready in cycle 0, rsp0_valid in cycle 2, rsp_result=12, rsp_flags=4'b0000.
- UMUL on port 1: a=32'hFFFF_FFFF, b=2, MUL_CYCLES=2 -> alu_ctl=0101 held 2 cycles, rsp_result=32'hFFFF_FFFE, rsp_result_hi=1, rsp1_valid only.
- Contention: both ports valid from reset with op 0000 -> grant order 0,1,0,1; each grant is spaced 3 cycles apart with rsp ready tied high.
- DIV by zero: port 0 issues a=10, b=0, op=0100 -> response after 1 EXEC cycle with result 32'hFFFF_FFFF, flags 4'b1000. Then DIV 100/7 -> result 14 after DIV_CYCLES=8 EXEC cycles.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and rsp_* stable for all 5 cycles, a pending port-1 request is not accepted until 1 cycle after rsp0_ready=1.
- Reset mid-op: reset driven low during the 4th EXEC cycle of a DIV -> all outputs 0 immediately and no response after release. Next tie is won by port 0.
